// File: rtl/branch_sequencer.sv
// Instruction sequencer: fetches 16-bit words, drives the ALU, resolves branches and owns the PC.
// Optional return stack for CALL/RET is enabled by defining SEQ_CALL_STACK_EN.
module branch_sequencer #(
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_req,
  input  logic          imem_ack,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_data,
  output logic [3:0]    cont,
  output logic [7:0]    opnd,
  output logic          alu_en,
  input  logic [7:0]    aluo,
  input  logic          aluc,
  output logic          tcnd,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          stack_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b0001;
  localparam logic [3:0] OP_CALL = 4'b0010;
  localparam logic [3:0] OP_RET  = 4'b0011;
  localparam logic [3:0] OP_JZ   = 4'b0100;
  localparam logic [3:0] OP_JNZ  = 4'b0101;
  localparam logic [3:0] OP_JC   = 4'b0110;
  localparam logic [3:0] OP_JNC  = 4'b0111;

  logic [2:0]    state;
  logic [3:0]    ir_op;
  logic [7:0]    ir_arg;
  logic          z;
  logic          c;
  logic          taken;
  logic          stack_fault;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] target;

  // Outputs decoded straight from state so an async reset drops imem_req at once.
  assign imem_req  = (state == S_FETCH);
  assign alu_en    = (state == S_EXEC);
  assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
  assign halted    = (state == S_HALT);
  assign imem_addr = pc;
  assign pc_inc    = pc + AW'(1);

`ifdef SEQ_CALL_STACK_EN
  localparam bit RET_TAKEN = 1'b1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0]  stack [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_dec;
  logic           stack_err_q;

  assign sp_dec      = sp - SPW'(1);
  assign stack_fault = ((cont == OP_CALL) && (sp == SPW'(STACK_DEPTH))) ||
                       ((cont == OP_RET) && (sp == '0));
  assign target      = (cont == OP_RET) ? stack[sp_dec[IW-1:0]] : AW'(opnd);
  assign stack_err   = stack_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp          <= '0;
      stack_err_q <= 1'b0;
    end else if (state == S_WB && !cont[3]) begin
      if (stack_fault)
        stack_err_q <= 1'b1;
      else if (cont == OP_CALL)
        sp <= sp + SPW'(1);
      else if (cont == OP_RET)
        sp <= sp_dec;
    end
  end

  // Entry storage needs no reset: the stack pointer alone defines what is valid.
  always_ff @(posedge clk) begin
    if (state == S_WB && cont == OP_CALL && !stack_fault)
      stack[sp[IW-1:0]] <= pc_inc;
  end
`else
  localparam bit RET_TAKEN = 1'b0;
  assign stack_fault = 1'b0;
  assign target      = AW'(opnd);
  assign stack_err   = 1'b0;
`endif

  always_comb begin
    taken = 1'b0;
    case (cont)
      OP_JMP, OP_CALL: taken = 1'b1;
      OP_RET:          taken = RET_TAKEN;
      OP_JZ:           taken = z;
      OP_JNZ:          taken = !z;
      OP_JC:           taken = c;
      OP_JNC:          taken = !c;
      default:         taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir_op  <= '0;
      ir_arg <= '0;
      cont   <= '0;
      opnd   <= '0;
      tcnd   <= 1'b0;
      z      <= 1'b0;
      c      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir_op  <= imem_data[15:12];
            ir_arg <= imem_data[7:0];
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          cont <= ir_op;
          opnd <= ir_arg;
          if (ir_op[3])
            state <= S_EXEC;
          else if (ir_op == OP_HALT)
            state <= S_HALT;
          else
            state <= S_WB;
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          state <= S_FETCH;
          if (cont[3]) begin
            z  <= (aluo == 8'h00);
            c  <= aluc;
            pc <= pc_inc;
          end else if (stack_fault) begin
            state <= S_HALT;
          end else begin
            tcnd <= taken;
            pc   <= taken ? target : pc_inc;
          end
        end
        S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic [3:0]  cont;
  logic [7:0]  opnd;
  logic        alu_en;
  logic [7:0]  aluo = 8'h00;
  logic        aluc = 1'b0;
  logic        tcnd;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        stack_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_pc;
  bit         m_z, m_c, m_tcnd, m_halted, m_err;
`ifdef SEQ_CALL_STACK_EN
  logic [7:0] m_stack [$];
`endif

  branch_sequencer #(.AW(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_addr(imem_addr), .imem_data(imem_data),
    .cont(cont), .opnd(opnd), .alu_en(alu_en), .aluo(aluo), .aluc(aluc),
    .tcnd(tcnd), .pc(pc), .busy(busy), .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_z = 0; m_c = 0; m_tcnd = 0; m_halted = 0; m_err = 0;
`ifdef SEQ_CALL_STACK_EN
    m_stack.delete();
`endif
  endtask

  // Instruction-level effect of one word on the architectural state.
  task automatic model_step(input logic [15:0] w, input logic [7:0] ao, input bit ac,
                            output int lat, output int alus);
    logic [3:0] op;
    logic [7:0] t;
    bit take;
    op = w[15:12];
    t  = w[7:0];
    alus = 0;
    lat  = 2;
    take = 0;
    if (op[3]) begin
      m_z = (ao == 8'h00); m_c = ac; m_pc = m_pc + 8'd1; lat = 3; alus = 1;
    end else if (op == 4'd0) begin
      m_halted = 1; lat = 1;
    end else begin
      case (op)
        4'd1: take = 1;
        4'd4: take = m_z;
        4'd5: take = !m_z;
        4'd6: take = m_c;
        4'd7: take = !m_c;
`ifdef SEQ_CALL_STACK_EN
        4'd2: begin
          if (m_stack.size() == 4) begin m_err = 1; m_halted = 1; end
          else begin m_stack.push_back(m_pc + 8'd1); m_pc = t; m_tcnd = 1; end
        end
        4'd3: begin
          if (m_stack.size() == 0) begin m_err = 1; m_halted = 1; end
          else begin m_pc = m_stack.pop_back(); m_tcnd = 1; end
        end
`else
        4'd2: take = 1;
        4'd3: take = 0;
`endif
        default: take = 0;
      endcase
`ifdef SEQ_CALL_STACK_EN
      if (op != 4'd2 && op != 4'd3) begin
        m_tcnd = take; m_pc = take ? t : m_pc + 8'd1;
      end
`else
      m_tcnd = take; m_pc = take ? t : m_pc + 8'd1;
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; start = 0; imem_ack = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    m_pc = 8'h00; m_z = 0; m_c = 0; m_halted = 0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_pc", pc, 8'h00);
    checkOutput("start_req", imem_req, 1);
  endtask

  task automatic applyStimulus(input logic [15:0] w, input int dly, input logic [7:0] ao, input bit ac);
    int guard = 0;
    int lat = 0;
    int alus = 0;
    int exp_lat, exp_alus;
    while (!imem_req && guard < 20) begin @(negedge clk); guard++; end
    checkOutput("fetch_req", imem_req, 1);
    checkOutput("fetch_addr", imem_addr, m_pc);
    repeat (dly) @(negedge clk);
    if (dly > 0) begin
      checkOutput("wait_req", imem_req, 1);
      checkOutput("wait_addr", imem_addr, m_pc);
      checkOutput("wait_pc", pc, m_pc);
    end
    imem_data = w; aluo = ao; aluc = ac; imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    imem_data = 16'($urandom);
    guard = 0;
    while (!imem_req && !halted && guard < 20) begin
      if (alu_en) alus++;
      lat++; guard++;
      @(negedge clk);
    end
    model_step(w, ao, ac, exp_lat, exp_alus);
    checkOutput("latency", lat, exp_lat);
    checkOutput("alu_en_pulses", alus, exp_alus);
    checkOutput("pc", pc, m_pc);
    checkOutput("tcnd", tcnd, m_tcnd);
    checkOutput("halted", halted, m_halted);
    checkOutput("stack_err", stack_err, m_err);
    checkOutput("cont", cont, w[15:12]);
    checkOutput("opnd", opnd, w[7:0]);
  endtask

  initial begin
    logic [3:0] op;
    model_reset();
    do_reset();
    @(negedge clk);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_addr", imem_addr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_cont", cont, 0);
    checkOutput("rst_opnd", opnd, 0);
    checkOutput("rst_alu_en", alu_en, 0);
    checkOutput("rst_tcnd", tcnd, 0);
    checkOutput("rst_stack_err", stack_err, 0);

    do_start();
    applyStimulus(16'h1033, 0, 8'h00, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checkOutput("midfetch_req", imem_req, 0);
    checkOutput("midfetch_pc", pc, 0);
    checkOutput("midfetch_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();

    do_start();
    applyStimulus(16'h8000, 0, 8'h00, 0);
    applyStimulus(16'h4040, 0, 8'h00, 0);
    checkOutput("jz_taken_pc", pc, 8'h40);
    checkOutput("jz_taken_tcnd", tcnd, 1);
    applyStimulus(16'h8000, 0, 8'h05, 0);
    applyStimulus(16'h4040, 0, 8'h00, 0);
    checkOutput("jz_not_pc", pc, 8'h42);
    checkOutput("jz_not_tcnd", tcnd, 0);

    applyStimulus(16'h9000, 1, 8'h11, 1);
    applyStimulus(16'h7010, 0, 8'h00, 0);
    checkOutput("jnc_tcnd", tcnd, 0);
    applyStimulus(16'h6010, 2, 8'h00, 0);
    checkOutput("jc_pc", pc, 8'h10);
    checkOutput("jc_tcnd", tcnd, 1);

    start = 1;
    applyStimulus(16'hA0AA, 5, 8'h00, 0);
    start = 0;
    checkOutput("alu_keeps_tcnd", tcnd, 1);

    applyStimulus(16'h10FF, 0, 8'h00, 0);
    applyStimulus(16'hF000, 0, 8'h01, 0);
    checkOutput("wrap_pc", pc, 8'h00);
    applyStimulus(16'h0000, 0, 8'h00, 0);
    checkOutput("halt_flag", halted, 1);
    repeat (3) @(negedge clk);
    checkOutput("halt_pc_frozen", pc, m_pc);
    do_start();

`ifdef SEQ_CALL_STACK_EN
    do_reset();
    do_start();
    applyStimulus(16'h1005, 0, 8'h00, 0);
    applyStimulus(16'h2020, 0, 8'h00, 0);
    applyStimulus(16'h3000, 0, 8'h00, 0);
    checkOutput("ret_pc", pc, 8'h06);
    for (int i = 0; i < 5; i++) applyStimulus(16'h2030 + 16'(i), 0, 8'h00, 0);
    checkOutput("overflow_err", stack_err, 1);
    checkOutput("overflow_halt", halted, 1);
    do_reset();
    do_start();
    applyStimulus(16'h3000, 0, 8'h00, 0);
    checkOutput("underflow_err", stack_err, 1);
    checkOutput("underflow_halt", halted, 1);
    do_reset();
    do_start();
`else
    applyStimulus(16'h2020, 0, 8'h00, 0);
    checkOutput("call_pc", pc, 8'h20);
    applyStimulus(16'h3000, 0, 8'h00, 0);
    checkOutput("ret_nop_pc", pc, 8'h21);
    checkOutput("ret_nop_tcnd", tcnd, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd0 && $urandom_range(0, 3) != 0) op = 4'd8;
      applyStimulus({op, 4'($urandom), 8'($urandom)}, $urandom_range(0, 3),
                    ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom), 1'($urandom));
      if (m_halted) do_start();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
